// File: rtl/serial_multiplier_if.sv
// Start/done handshake and operand/result bus for the serial multiplier.
// The requester side uses the master modport and the multiplier uses the slave modport.
interface serial_multiplier_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 start;
    logic                 signed_op;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start,
        output signed_op,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  signed_op,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/serial_multiplier.sv
// Iterative shift-add multiplier that handles one partial product per clock.
// Signed operands are multiplied as magnitudes, and the sign is applied once at the end.
// Latency is fixed at WIDTH+1 edges from acceptance to the done pulse, and there is no early exit.
module serial_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input logic                clk,
    input logic                rst_n,
    serial_multiplier_if.slave bus_io
);
    localparam int unsigned ProdW = 2 * WIDTH;
    localparam int unsigned CntW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    state_e             state_q, state_d;
    logic [ProdW-1:0]   acc_q, acc_d;
    logic [ProdW-1:0]   mcand_q, mcand_d;   // multiplicand magnitude, pre-shifted to the step weight
    logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier magnitude, consumed LSB first
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [ProdW-1:0]   product_q, product_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Operand magnitudes: the most negative value wraps to 2^(WIDTH-1), which is still correct unsigned.
    always_comb begin
        mag_a = bus_io.multiplicand;
        mag_b = bus_io.multiplier;
        if (bus_io.signed_op && bus_io.multiplicand[WIDTH-1]) begin
            mag_a = (~bus_io.multiplicand) + WIDTH'(1);
        end
        if (bus_io.signed_op && bus_io.multiplier[WIDTH-1]) begin
            mag_b = (~bus_io.multiplier) + WIDTH'(1);
        end
    end

    // Next-state and datapath updates for the IDLE -> RUN -> FINISH sequence
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = bus_io.signed_op &
                               (bus_io.multiplicand[WIDTH-1] ^ bus_io.multiplier[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                product_d = neg_q ? ((~acc_q) + ProdW'(1)) : acc_q;
                done_d    = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, with synchronous clear on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign bus_io.busy    = (state_q != StIdle);
    assign bus_io.done    = done_q;
    assign bus_io.product = product_q;
endmodule

// File: doc/serial_multiplier.md
Name: serial_multiplier

Overview:
Iterative shift-add multiplier, the inverse-operation companion to the team's serial divider. It uses the same start/done handshake and produces one partial-product step per clock. It supports unsigned and two's-complement signed operands, selected per operation. It sits beside the divider in the arithmetic engine, where area matters more than latency.

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
start  input  1  request; accepted only while idle (busy=0).
signed_op  input  1  1 = operands are two's complement; 0 = unsigned; sampled with start.
multiplicand  input  WIDTH  operand A; sampled with start.
multiplier  input  WIDTH  operand B; sampled with start.
busy  output  1  high from the edge after acceptance until the result is registered.
done  output  1  one-cycle pulse: product valid and newly updated.
product  output  2*WIDTH  result; holds its value until the next completion.

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, product=0; internal counter and accumulators cleared. Reset mid-operation abandons the operation silently; no done pulse.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On an edge with start=1, latch the operands and signed_op.
  - When signed_op=1, store magnitudes |A| and |B| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits).
  - Latch neg = signed_op & (A[MSB] ^ B[MSB]).
  - Clear accumulator (2*WIDTH bits) and counter; go to RUN; busy=1.
- RUN: one step per edge, WIDTH steps.
  - If the current multiplier LSB is 1, acc += multiplicand_mag shifted left by the step index (or an equivalent right-shifting accumulator).
  - Multiplier register shifts right.
  - Counter increments.
  - After step WIDTH (the counter reaches WIDTH), go to FINISH.
- FINISH (one edge):
  - product = neg ? (~acc + 1) : acc, truncated to 2*WIDTH bits.
  - done=1, busy=0; go to IDLE.
- Latency:
  - Acceptance edge E0; RUN edges E1..E_WIDTH; FINISH at E_(WIDTH+1).
  - done is high for exactly the cycle after E_(WIDTH+1). For WIDTH=16, that is 17 edges after acceptance.
- done clears on the next edge unconditionally.
- start while busy=1 (RUN or FINISH) is ignored, with no queuing. Operands and signed_op may change freely while busy.
- start asserted in the same cycle that done=1: accepted, because the state is IDLE. done drops and busy rises on that edge. product keeps the previous result until the next FINISH.
- start held high continuously: back-to-back operations, one accepted every WIDTH+2 edges.
- Zero operands need no special case. The full WIDTH steps always run; there is no early termination.
- Width rules:
  - Unsigned: exact 2*WIDTH-bit product, no overflow possible.
  - Signed: exact two's-complement 2*WIDTH-bit product, including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
- product is only written in FINISH and in reset.

Test Plan:
- Reset, then unsigned 3 x 5 -> product=0x0000000F, done pulses once, 17 edges after acceptance; busy high for edges 1..16 after acceptance.
- Unsigned 0xFFFF x 0xFFFF -> 0xFFFE0001. Signed 0xFFFF x 0xFFFF (-1 x -1) -> 0x00000001.
- Signed 0xFFFD x 0x0007 (-3 x 7) -> 0xFFFFFFEB. Signed 0x8000 x 0x8000 -> 0x40000000. Signed 0x8000 x 0x0001 -> 0xFFFF8000.
- Start 10 x 10, then pulse start with 2 x 2 and change the operands at edge 5 while busy -> only 0x00000064 is produced, a single done pulse, and the second request is dropped.
- Start held high with alternating operand pairs (6 x 7, then 0 x 0x1234) -> results 0x0000002A then 0x00000000, with done pulses exactly 18 edges apart.
- Deassert rst_n at edge 8 of an operation -> next cycle busy=0, done=0, product=0, and no later done pulse. A new start after reset release completes normally.
